// File: rtl/clk_freq_meter_if.sv
// Measurement bundle between the frequency meter and its user.
// sig_in/start_in feed the meter; count/valid/status come back.
interface clk_freq_meter_if #(
    parameter int CNT_W = 24
);
    logic             sig_in;
    logic             start_in;
    logic [CNT_W-1:0] count_out;
    logic             valid_out;
    logic             overflow_out;
    logic             stalled_out;
    logic             busy_out;

    // master: the block that drives the signal and reads results
    modport master (
        output sig_in,
        output start_in,
        input  count_out,
        input  valid_out,
        input  overflow_out,
        input  stalled_out,
        input  busy_out
    );

    // slave: the meter itself
    modport slave (
        input  sig_in,
        input  start_in,
        output count_out,
        output valid_out,
        output overflow_out,
        output stalled_out,
        output busy_out
    );
endinterface

// File: rtl/clk_freq_meter.sv
// Counts rising edges of an asynchronous clock over a fixed gate window.
// Ports: clk_in, rst_n_in (async, active-low), mon (slave bundle).
module clk_freq_meter #(
    parameter int CLK_HZ      = 120000000,
    parameter int GATE_CYCLES = 120000,
    parameter int CNT_W       = 24,
    parameter bit CONTINUOUS  = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    clk_freq_meter_if.slave  mon
);

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    if (GATE_CYCLES < 2 || CLK_HZ <= 0) begin : g_bad_param
        $error("clk_freq_meter: GATE_CYCLES must be >= 2, CLK_HZ > 0");
    end

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic               s3_q, s3_d;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic               sat_q, sat_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               stall_q, stall_d;
    logic               edge_pulse;

    // s1/s2 resolve metastability; s3 only delays s2 for edge detect
    assign edge_pulse = s2_q & ~s3_q;

    always_comb begin
        state_d    = state_q;
        s1_d       = mon.sig_in;
        s2_d       = s1_q;
        s3_d       = s2_q;
        gate_d     = gate_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        stall_d    = stall_q;

        unique case (state_q)
            IDLE: begin
                if (CONTINUOUS || mon.start_in) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                gate_d     = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                state_d    = MEASURE;
            end
            MEASURE: begin
                if (edge_pulse) begin
                    if (edge_cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                end
                gate_d = gate_q + 1'b1;
                // Result registers load on the way into DONE so that
                // the new value is already visible during the strobe.
                if (gate_q == GATE_LAST) begin
                    gate_d  = '0;
                    state_d = DONE;
                    count_d = edge_cnt_d;
                    ovf_d   = sat_d;
                    stall_d = (edge_cnt_d == '0);
                end
            end
            DONE: begin
                state_d = CONTINUOUS ? ARM : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            gate_q     <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            gate_q     <= gate_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            stall_q    <= stall_d;
        end
    end

    assign mon.count_out    = count_q;
    assign mon.overflow_out = ovf_q;
    assign mon.stalled_out  = stall_q;
    assign mon.valid_out    = (state_q == DONE);
    assign mon.busy_out     = (state_q == ARM) || (state_q == MEASURE);

endmodule

// File: tb/tb_clk_freq_meter.sv
// Bench for clk_freq_meter: three instances (continuous 8-bit,
// continuous 4-bit, one-shot 8-bit), scoreboard per instance.
module tb_clk_freq_meter;

    typedef struct {
        int   lo;
        int   hi;
        logic ovf;
        logic stl;
        int   gap;
        bit   any;
    } exp_t;

    logic clk;
    logic rst_n;
    logic c_start;
    logic sig_v [3];
    int   hi [3];
    int   lo [3];
    int   ph [3];
    int   cyc;
    int   n_vec;
    int   n_err;
    int   a_seen, a_last;
    int   b_seen, b_last;
    int   c_seen, c_vcyc;
    logic c_busy_seen;
    exp_t aq [$];
    exp_t bq [$];
    exp_t cq [$];

    clk_freq_meter_if #(.CNT_W(8)) a_if ();
    clk_freq_meter_if #(.CNT_W(4)) b_if ();
    clk_freq_meter_if #(.CNT_W(8)) c_if ();

    assign a_if.sig_in   = sig_v[0];
    assign b_if.sig_in   = sig_v[1];
    assign c_if.sig_in   = sig_v[2];
    assign a_if.start_in = 1'b0;
    assign b_if.start_in = 1'b0;
    assign c_if.start_in = c_start;

    clk_freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .CONTINUOUS(1'b1))
    u_a (.clk_in(clk), .rst_n_in(rst_n), .mon(a_if.slave));

    clk_freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .CONTINUOUS(1'b1))
    u_b (.clk_in(clk), .rst_n_in(rst_n), .mon(b_if.slave));

    clk_freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .CONTINUOUS(1'b0))
    u_c (.clk_in(clk), .rst_n_in(rst_n), .mon(c_if.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Signal generators: high for hi cycles, low for lo cycles
    initial begin
        for (int i = 0; i < 3; i++) begin
            sig_v[i] = 1'b0;
            hi[i] = 0;
            lo[i] = 0;
            ph[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (hi[i] == 0) begin
                    sig_v[i] = 1'b0;
                end else begin
                    sig_v[i] = (ph[i] < hi[i]);
                    ph[i] = (ph[i] + 1 >= hi[i] + lo[i]) ? 0 : ph[i] + 1;
                end
            end
        end
    end

    function automatic exp_t mk(input int l, input int h, input logic o,
                                input logic s, input int g, input bit a);
        exp_t e;
        e.lo = l; e.hi = h; e.ovf = o; e.stl = s; e.gap = g; e.any = a;
        return e;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_res(input string tag, input exp_t e, input int cnt,
                             input logic ovf, input logic stl, input int gap);
        if (!e.any) begin
            n_vec++;
            assert (cnt >= e.lo && cnt <= e.hi) else begin
                n_err++;
                $error("FAIL %s_count observed %0d expected %0d..%0d",
                       tag, cnt, e.lo, e.hi);
            end
            n_vec++;
            assert (ovf === e.ovf) else begin
                n_err++;
                $error("FAIL %s_ovf observed %b expected %b", tag, ovf, e.ovf);
            end
            n_vec++;
            assert (stl === e.stl) else begin
                n_err++;
                $error("FAIL %s_stall observed %b expected %b", tag, stl, e.stl);
            end
        end
        if (e.gap != 0) begin
            n_vec++;
            assert (gap === e.gap) else begin
                n_err++;
                $error("FAIL %s_gap observed %0d expected %0d", tag, gap, e.gap);
            end
        end
    endtask

    // Result monitors: pop one expectation per valid strobe
    initial begin
        exp_t e;
        a_seen = 0; a_last = 0;
        forever begin
            @(negedge clk);
            if (a_if.valid_out === 1'b1) begin
                a_seen++;
                if (aq.size() > 0) begin
                    e = aq.pop_front();
                    check_res("A", e, int'(a_if.count_out), a_if.overflow_out,
                              a_if.stalled_out, cyc - a_last);
                end
                a_last = cyc;
            end
        end
    end

    initial begin
        exp_t e;
        b_seen = 0; b_last = 0;
        forever begin
            @(negedge clk);
            if (b_if.valid_out === 1'b1) begin
                b_seen++;
                if (bq.size() > 0) begin
                    e = bq.pop_front();
                    check_res("B", e, int'(b_if.count_out), b_if.overflow_out,
                              b_if.stalled_out, cyc - b_last);
                end
                b_last = cyc;
            end
        end
    end

    initial begin
        exp_t e;
        c_seen = 0; c_vcyc = 0; c_busy_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (c_if.busy_out === 1'b1) c_busy_seen = 1'b1;
            if (c_if.valid_out === 1'b1) begin
                c_seen++;
                c_vcyc = cyc;
                if (cq.size() > 0) begin
                    e = cq.pop_front();
                    check_res("C", e, int'(c_if.count_out), c_if.overflow_out,
                              c_if.stalled_out, 0);
                end
            end
        end
    end

    task automatic set_pat(input int i, input int h, input int l);
        hi[i] = h;
        lo[i] = l;
        ph[i] = 0;
    endtask

    task automatic wait_valid_a(input int limit);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (a_if.valid_out !== 1'b1 && k < limit);
        chk("A_valid_wait", int'(a_if.valid_out), 1);
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while ((aq.size() + bq.size() + cq.size()) != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("drain_left", aq.size() + bq.size() + cq.size(), 0);
        aq.delete();
        bq.delete();
        cq.delete();
    endtask

    initial begin
        int st;
        int a_snap;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        c_start = 1'b0;
        set_pat(0, 5, 5);
        set_pat(1, 2, 2);
        set_pat(2, 5, 5);
        repeat (5) @(negedge clk);

        // Reset state
        chk("rst_A_count", int'(a_if.count_out), 0);
        chk("rst_A_valid", int'(a_if.valid_out), 0);
        chk("rst_A_busy", int'(a_if.busy_out), 0);
        chk("rst_A_stall", int'(a_if.stalled_out), 0);
        chk("rst_B_ovf", int'(b_if.overflow_out), 0);
        chk("rst_C_busy", int'(c_if.busy_out), 0);

        // Period 10 on A, period 4 saturating a 4-bit counter on B
        aq.push_back(mk(9, 11, 1'b0, 1'b0, 0, 1'b0));
        repeat (3) aq.push_back(mk(10, 10, 1'b0, 1'b0, 102, 1'b0));
        bq.push_back(mk(15, 15, 1'b1, 1'b0, 0, 1'b0));
        bq.push_back(mk(15, 15, 1'b1, 1'b0, 102, 1'b0));
        rst_n = 1'b1;
        drain(600);

        // One-shot instance: idle without start
        chk("C_idle_valids", c_seen, 0);
        chk("C_idle_busy", int'(c_busy_seen), 0);
        cq.push_back(mk(10, 10, 1'b0, 1'b0, 0, 1'b0));
        @(negedge clk);
        c_start = 1'b1;
        st = cyc;
        @(negedge clk);
        c_start = 1'b0;
        repeat (5) @(negedge clk);
        chk("C_busy_measure", int'(c_if.busy_out), 1);
        repeat (45) @(negedge clk);
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        for (int k = 0; k < 200 && c_seen == 0; k++) @(negedge clk);
        chk("C_one_result", c_seen, 1);
        chk("C_latency", c_vcyc - st, 102);
        repeat (250) @(negedge clk);
        chk("C_no_extra", c_seen, 1);
        chk("C_busy_after", int'(c_if.busy_out), 0);
        drain(10);

        // Period 7 (4 high / 3 low): 14 or 15 edges
        wait_valid_a(200);
        #1;
        set_pat(0, 4, 3);
        aq.push_back(mk(0, 0, 1'b0, 1'b0, 102, 1'b1));
        repeat (3) aq.push_back(mk(14, 15, 1'b0, 1'b0, 102, 1'b0));
        drain(500);

        // Stalled input, then back to period 10
        wait_valid_a(200);
        #1;
        set_pat(0, 0, 0);
        aq.push_back(mk(0, 0, 1'b0, 1'b0, 102, 1'b1));
        aq.push_back(mk(0, 0, 1'b0, 1'b1, 102, 1'b0));
        wait_valid_a(200);
        wait_valid_a(200);
        #1;
        set_pat(0, 5, 5);
        aq.push_back(mk(10, 10, 1'b0, 1'b0, 102, 1'b0));
        drain(200);

        // Reset in the middle of a window
        wait_valid_a(200);
        #1;
        repeat (50) @(negedge clk);
        chk("A_busy_mid", int'(a_if.busy_out), 1);
        chk("A_count_mid", int'(a_if.count_out), 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_A_count", int'(a_if.count_out), 0);
        chk("arst_A_busy", int'(a_if.busy_out), 0);
        chk("arst_A_valid", int'(a_if.valid_out), 0);
        chk("arst_B_count", int'(b_if.count_out), 0);
        chk("arst_B_ovf", int'(b_if.overflow_out), 0);
        a_snap = a_seen;
        repeat (20) @(negedge clk);
        chk("arst_no_valid", a_seen - a_snap, 0);
        aq.push_back(mk(9, 11, 1'b0, 1'b0, 0, 1'b0));
        aq.push_back(mk(10, 10, 1'b0, 1'b0, 102, 1'b0));
        rst_n = 1'b1;
        drain(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
